// File: rtl/shuffler_sched_pkg.sv
// Shared constants and stage-geometry helpers for the MDC shuffler sequencer.
package fft_shuffle_pkg;

  localparam int LOG2N_DEFAULT = 4;

  // Chain latency for the default size: the sum of all stage delays is N/2-1.
  localparam int TOTAL_LAT = (1 << (LOG2N_DEFAULT - 1)) - 1;

  // Delay-line depth (in pairs) of shuffler stage k.
  function automatic int stage_delay(input int log2n, input int k);
    return 1 << (log2n - 2 - k);
  endfunction

  // Cycles between a pair entering stage 0 and reaching stage k.
  function automatic int stage_offset(input int log2n, input int k);
    int acc;
    acc = 0;
    for (int j = 0; j < k; j++) acc += stage_delay(log2n, j);
    return acc;
  endfunction

endpackage

// File: rtl/shuffler_sched_if.sv
// Handshake and status bundle between the frame source and the sequencer.
interface shuffler_sched_if #(
  parameter int LOG2N = 4
);
  logic             in_valid;
  logic             in_sof;
  logic             err_clr;
  logic [LOG2N-2:0] sel;
  logic             out_valid;
  logic             out_sof;
  logic             busy;
  logic             err;

  modport master (
    output in_valid, in_sof, err_clr,
    input  sel, out_valid, out_sof, busy, err
  );

  modport slave (
    input  in_valid, in_sof, err_clr,
    output sel, out_valid, out_sof, busy, err
  );
endinterface

// File: rtl/shuffler_sched_stage.sv
// Per-stage sequencer: aligns valid/sof to the stage, counts the pair index
// and derives the pass/swap select. Stage 0 also flags framing errors.
module shuffle_stage_seq
  import fft_shuffle_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEFAULT,
  parameter int STAGE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic v_in,     // valid track of the previous stage (stage 0: live input)
  input  logic s_in,     // sof track of the previous stage
  output logic v,        // valid as seen by this stage
  output logic s,        // sof as seen by this stage
  output logic sel,      // 0 = pass, 1 = swap
  output logic err_set   // framing violation seen this cycle (stage 0 only)
);
  localparam int CW     = LOG2N - 1;
  localparam int SELBIT = LOG2N - 2 - STAGE;

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] idx;

  generate
    if (STAGE == 0) begin : g_head
      logic v_prev_reg;

      assign v = v_in;
      assign s = s_in;

      // Remember last cycle's valid so a mid-frame drop is caught on its falling edge only.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v_prev_reg <= 1'b0;
        else        v_prev_reg <= v;
      end

      // Premature sof, orphan pair (counts as index 0), or valid falling mid-frame.
      assign err_set = (s && (cnt_reg != '0)) ||
                       (v && !s && (cnt_reg == '0)) ||
                       (!v && v_prev_reg && (cnt_reg != '0));
    end else begin : g_tail
      localparam int DLY = stage_delay(LOG2N, STAGE - 1);

      logic [DLY-1:0] v_sr_reg;
      logic [DLY-1:0] s_sr_reg;

      if (DLY == 1) begin : g_one
        // Single-pair alignment delay behind the previous stage.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_sr_reg <= '0;
            s_sr_reg <= '0;
          end else begin
            v_sr_reg <= v_in;
            s_sr_reg <= s_in;
          end
        end
      end else begin : g_many
        // Free-running shift line matching the previous stage's data delay.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_sr_reg <= '0;
            s_sr_reg <= '0;
          end else begin
            v_sr_reg <= {v_sr_reg[DLY-2:0], v_in};
            s_sr_reg <= {s_sr_reg[DLY-2:0], s_in};
          end
        end
      end

      assign v       = v_sr_reg[DLY-1];
      assign s       = s_sr_reg[DLY-1];
      assign err_set = 1'b0;
    end
  endgenerate

  // A sof forces the index to 0 so a restarted frame realigns immediately.
  assign idx = s ? '0 : cnt_reg;
  assign sel = v & idx[SELBIT];

  // Pair counter advances only on valid pairs and wraps at N/2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  cnt_reg <= '0;
    else if (v)  cnt_reg <= idx + CW'(1);
  end

endmodule

// File: rtl/shuffler_sched.sv
// Select/framing sequencer for a chain of 2-parallel MDC FFT shufflers.
module shuffler_sched
  import fft_shuffle_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  shuffler_sched_if.slave bus
);
  localparam int NSTAGES = LOG2N - 1;

  // chain[0] is the live input; chain[k+1] is the track as seen by stage k.
  logic [NSTAGES:0]   v_chain;
  logic [NSTAGES:0]   s_chain;
  logic [NSTAGES-1:0] sel_vec;
  logic [NSTAGES-1:0] err_set;
  logic               out_valid_reg;
  logic               out_sof_reg;
  logic               err_reg;

  // Gating with rst_n keeps the combinational stage-0 select quiet while reset is held.
  assign v_chain[0] = bus.in_valid & rst_n;
  assign s_chain[0] = bus.in_sof & v_chain[0];

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
      shuffle_stage_seq #(
        .LOG2N (LOG2N),
        .STAGE (gi)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .v_in    (v_chain[gi]),
        .s_in    (s_chain[gi]),
        .v       (v_chain[gi+1]),
        .s       (s_chain[gi+1]),
        .sel     (sel_vec[gi]),
        .err_set (err_set[gi])
      );
    end
  endgenerate

  // The last stage always has a one-pair delay line; this closes the chain latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
    end else begin
      out_valid_reg <= v_chain[NSTAGES];
      out_sof_reg   <= s_chain[NSTAGES];
    end
  end

  // Sticky framing error; a new violation wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            err_reg <= 1'b0;
    else if (|err_set)     err_reg <= 1'b1;
    else if (bus.err_clr)  err_reg <= 1'b0;
  end

  assign bus.sel       = sel_vec;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sof   = out_sof_reg;
  assign bus.busy      = (|v_chain[NSTAGES:1]) | out_valid_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_shuffler_sched.sv
// Scoreboard bench: drives an N=16 and an N=8 sequencer side by side and
// compares them against a pair-index model of the scheduling rules.
module tb_shuffler_sched;

  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] tv, ts, tc;

  always #5 clk = ~clk;

  shuffler_sched_if #(.LOG2N(4)) b16 ();
  shuffler_sched_if #(.LOG2N(3)) b8 ();

  assign b16.in_valid = tv[0];
  assign b16.in_sof   = ts[0];
  assign b16.err_clr  = tc[0];
  assign b8.in_valid  = tv[1];
  assign b8.in_sof    = ts[1];
  assign b8.err_clr   = tc[1];

  shuffler_sched #(.LOG2N(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  shuffler_sched #(.LOG2N(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  logic [3:0] got_sel [2];
  logic [1:0] got_ov, got_os, got_busy, got_err;

  assign got_sel[0] = {1'b0, b16.sel};
  assign got_sel[1] = {2'b00, b8.sel};
  assign got_ov     = {b8.out_valid, b16.out_valid};
  assign got_os     = {b8.out_sof, b16.out_sof};
  assign got_busy   = {b8.busy, b16.busy};
  assign got_err    = {b8.err, b16.err};

  // ---------------- reference model state ----------------
  typedef struct {
    int t;
    bit sof;
  } oexp_t;

  bit       hv   [2][MAXC];
  int       hidx [2][MAXC];
  int       cnt_m   [2];
  bit       vprev_m [2];
  bit       err_m   [2];
  bit [3:0] exp_sel  [2];
  bit       exp_busy [2];
  bit       exp_err  [2];
  oexp_t    q0[$], q1[$];

  int cyc = 0;
  int cur = -1;
  int n_chk = 0;
  int n_fail = 0;
  int pos [2];

  function automatic int lgn(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  // Cycles from the chain input to stage k: sum of the deeper stages' delays.
  function automatic int off(int lg, int k);
    int a = 0;
    for (int j = 0; j < k; j++) a += 1 << (lg - 2 - j);
    return a;
  endfunction

  function automatic void check(string name, int d, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cur, got, exp);
    end
  endfunction

  function automatic bit pop_exp(int d, output oexp_t e);
    e = '{t: 0, sof: 1'b0};
    if (d == 0) begin
      if (q0.size() == 0) return 1'b0;
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) return 1'b0;
      e = q1.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic bit head_due(int d);
    if (d == 0) return (q0.size() != 0) && (q0[0].t <= cur);
    return (q1.size() != 0) && (q1[0].t <= cur);
  endfunction

  // Each input pair gets a frame index once; every stage just sees that pair
  // again after its offset, and the output after N/2-1 cycles.
  task automatic model_step(int d, bit v, bit s, bit c, bit rn, int t);
    int lg   = lgn(d);
    int half = 1 << (lg - 1);
    int tl   = half - 1;
    int idx;
    int tt;
    bit set;
    if (!rn) begin
      v = 1'b0;
      for (int j = 0; j <= tl; j++) if (t - j >= 0) hv[d][t-j] = 1'b0;
      cnt_m[d] = 0;
      vprev_m[d] = 1'b0;
      err_m[d] = 1'b0;
      if (d == 0) q0.delete(); else q1.delete();
    end
    s   = s & v;
    idx = s ? 0 : cnt_m[d];
    hv[d][t]   = v;
    hidx[d][t] = idx;
    exp_sel[d]  = '0;
    exp_busy[d] = 1'b0;
    for (int k = 0; k < lg - 1; k++) begin
      tt = t - off(lg, k);
      if (tt >= 0 && hv[d][tt]) begin
        exp_busy[d]   = 1'b1;
        exp_sel[d][k] = bit'((hidx[d][tt] >> (lg - 2 - k)) & 1);
      end
    end
    if (t - tl >= 0 && hv[d][t-tl]) exp_busy[d] = 1'b1;
    exp_err[d] = err_m[d];
    if (v) begin
      if (d == 0) q0.push_back('{t: t + tl, sof: s});
      else        q1.push_back('{t: t + tl, sof: s});
    end
    if (rn) begin
      set = (s && cnt_m[d] != 0) || (v && !s && cnt_m[d] == 0) ||
            (!v && vprev_m[d] && cnt_m[d] != 0);
      err_m[d]   = set ? 1'b1 : (c ? 1'b0 : err_m[d]);
      vprev_m[d] = v;
      if (v) cnt_m[d] = (idx + 1) % half;
    end
  endtask

  task automatic tick(bit [1:0] v, bit [1:0] s, bit [1:0] c, bit rn);
    @(posedge clk);
    #1;
    rst_n = rn;
    tv = v;
    ts = s;
    tc = c;
    model_step(0, v[0], s[0], c[0], rn, cyc);
    model_step(1, v[1], s[1], c[1], rn, cyc);
    cur = cyc;
    cyc++;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    oexp_t e;
    if (cur >= 0) begin
      for (int d = 0; d < 2; d++) begin
        check("sel", d, int'(got_sel[d]), int'(exp_sel[d]));
        check("busy", d, int'(got_busy[d]), int'(exp_busy[d]));
        check("err", d, int'(got_err[d]), int'(exp_err[d]));
        if (got_ov[d]) begin
          n_chk++;
          if (!pop_exp(d, e)) begin
            n_fail++;
            $display("FAIL out_valid dut%0d cycle %0d: got 1 expected 0 (no pair pending)", d, cur);
          end else if (e.t != cur || e.sof != got_os[d]) begin
            n_fail++;
            $display("FAIL out_pair dut%0d cycle %0d: got sof %0b expected sof %0b at cycle %0d",
                     d, cur, got_os[d], e.sof, e.t);
          end else begin
            $display("dut%0d cycle %0d out pair sof=%0b", d, cur, got_os[d]);
          end
        end else begin
          check("out_sof_idle", d, int'(got_os[d]), 0);
          n_chk++;
          if (head_due(d)) begin
            n_fail++;
            $display("FAIL out_valid dut%0d cycle %0d: got 0 expected 1", d, cur);
            void'(pop_exp(d, e));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit [1:0] v, s, c;
    bit       rn;
    int       r;
    int       half;
    rst_n = 1'b0;
    tv = '0;
    ts = '0;
    tc = '0;
    pos[0] = -1;
    pos[1] = -1;

    repeat (3) tick(2'b00, 2'b00, 2'b00, 1'b0);
    repeat (2) tick(2'b00, 2'b00, 2'b00, 1'b1);

    // single frame on each DUT
    for (int i = 0; i < 16; i++)
      tick({1'(i < 4), 1'(i < 8)}, {1'(i == 0), 1'(i == 0)}, 2'b00, 1'b1);

    // back-to-back frames
    for (int i = 0; i < 24; i++)
      tick({1'(i < 8), 1'(i < 16)},
           {1'(i < 8 && i % 4 == 0), 1'(i < 16 && i % 8 == 0)}, 2'b00, 1'b1);

    // gap at pair 3, clear, then premature sof together with a clear, then clear
    for (int i = 0; i < 26; i++)
      tick({1'(i < 3 || (i >= 10 && i < 14)), 1'(i < 3 || (i >= 10 && i < 18))},
           {2{1'(i == 0 || i == 10)}},
           {2{1'(i == 7 || i == 10 || i == 24)}}, 1'b1);

    // premature sof mid-frame
    for (int i = 0; i < 22; i++)
      tick({1'(i < 6), 1'(i < 13)},
           {1'(i == 0 || i == 2), 1'(i == 0 || i == 5)},
           {2{1'(i == 20)}}, 1'b1);

    // reset asserted mid-frame with valid still high, then a fresh frame
    for (int i = 0; i < 24; i++)
      tick({1'(i < 7 || (i >= 9 && i < 13)), 1'(i < 7 || (i >= 9 && i < 17))},
           {2{1'(i == 0 || i == 9)}}, 2'b00, 1'(i != 5 && i != 6));

    // randomized traffic: mostly legal frames with occasional violations
    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < 2; d++) begin
        half = 1 << (lgn(d) - 1);
        r = int'($urandom_range(0, 99));
        v[d] = 1'b0;
        s[d] = 1'b0;
        if (pos[d] < 0) begin
          if (r < 45) begin
            v[d] = 1'b1; s[d] = 1'b1; pos[d] = 1;
          end else if (r < 48) begin
            v[d] = 1'b1;
          end
        end else begin
          if (r < 3) begin
            pos[d] = -1;
          end else if (r < 6) begin
            v[d] = 1'b1; s[d] = 1'b1; pos[d] = 1;
          end else begin
            v[d] = 1'b1; pos[d]++;
          end
        end
        if (pos[d] >= half) pos[d] = -1;
        c[d] = ($urandom_range(0, 19) == 0);
      end
      rn = ($urandom_range(0, 399) != 0);
      if (!rn) begin
        pos[0] = -1;
        pos[1] = -1;
      end
      tick(v, s, c, rn);
    end

    repeat (20) tick(2'b00, 2'b00, 2'b11, 1'b1);
    @(negedge clk);
    #1;
    check("drain_q16", 0, q0.size(), 0);
    check("drain_q8", 1, q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
